// File: rtl/instmem.sv
// Instruction memory for the 19-bit CPU: single port, synchronous write-first
// write, registered read. Optional per-word even parity under INSTMEM_PARITY_EN.
module instmem #(
    parameter int unsigned DATA_W = 19,
    parameter int unsigned ADDR_W = 14,
    parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_IM,
    input  logic [ADDR_W-1:0] addIM,
    input  logic [DATA_W-1:0] dataIM,
    output logic [DATA_W-1:0] outIM,
    output logic              par_err
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];
    logic              wrEn;

    // Writes are suppressed while reset is held; array contents are never cleared.
    assign wrEn = rst_n & we_IM;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[addIM] <= dataIM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            outIM <= '0;
        end else if (we_IM) begin
            outIM <= dataIM;
        end else begin
            outIM <= mem[addIM];
        end
    end

`ifdef INSTMEM_PARITY_EN
    logic parMem [0:DEPTH-1];
    logic rdParErr;

    always_ff @(posedge clk) begin
        if (wrEn) begin
            parMem[addIM] <= ^dataIM;
        end
    end

    assign rdParErr = (^mem[addIM]) != parMem[addIM];

    // Write-first forwards dataIM, whose parity is consistent by construction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            par_err <= 1'b0;
        end else if (we_IM) begin
            par_err <= 1'b0;
        end else begin
            par_err <= rdParErr;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_instmem.sv
// Self-checking bench for instmem: directed scenarios followed by randomized
// traffic checked against an associative-array reference model.
module tb_instmem;

    localparam int unsigned DATA_W = 19;
    localparam int unsigned ADDR_W = 14;

    logic              clk;
    logic              rst_n;
    logic              we_IM;
    logic [ADDR_W-1:0] addIM;
    logic [DATA_W-1:0] dataIM;
    logic [DATA_W-1:0] outIM;
    logic              par_err;

    int total;
    int bad;

    // Reference model: only words actually written are known.
    logic [DATA_W-1:0] model   [int];
    bit                corrupt [int];

    instmem #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_IM  (we_IM),
        .addIM  (addIM),
        .dataIM (dataIM),
        .outIM  (outIM),
        .par_err(par_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Apply inputs, clock once, settle past the edge, update the model.
    task automatic cycle(input logic rst, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
        rst_n  = rst;
        we_IM  = we;
        addIM  = a;
        dataIM = d;
        @(posedge clk);
        #1;
        if (rst && we) begin
            model[int'(a)]   = d;
            corrupt[int'(a)] = 1'b0;
        end
    endtask

    // Expected outputs derived from the model for the cycle just applied.
    task automatic checkOut(input string tag, input logic rst, input logic we,
                            input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        logic expErr;
        if (!rst) begin
            check({tag, "_rstOut"}, 32'(outIM), 32'd0);
            check({tag, "_rstPar"}, 32'(par_err), 32'd0);
        end else if (we) begin
            check({tag, "_wfOut"}, 32'(outIM), 32'(d));
            check({tag, "_wfPar"}, 32'(par_err), 32'd0);
        end else if (model.exists(int'(a))) begin
            expErr = 1'b0;
`ifdef INSTMEM_PARITY_EN
            expErr = corrupt[int'(a)];
`endif
            check({tag, "_rdOut"}, 32'(outIM), 32'(model[int'(a)]));
            check({tag, "_rdPar"}, 32'(par_err), 32'(expErr));
        end else begin
`ifndef INSTMEM_PARITY_EN
            check({tag, "_unwPar"}, 32'(par_err), 32'd0);
`endif
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic we,
                        input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        cycle(rst, we, a, d);
        checkOut(tag, rst, we, a, d);
    endtask

    initial begin
        logic [ADDR_W-1:0] hiAddr;
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;
        logic              rr;
        logic              rw;
        total  = 0;
        bad    = 0;
        hiAddr = '1;

        // Reset with a pending write that must be suppressed.
        @(negedge clk);
        step("reset0", 1'b0, 1'b1, 14'd0, 19'h00381);
        step("reset1", 1'b0, 1'b1, 14'd0, 19'h00381);
        cycle(1'b1, 1'b0, 14'd0, 19'h0);
        check("rstNoWrite", 32'(outIM === 19'h00381), 32'd0);
        check("rstNoWritePar", 32'(par_err), 32'd0);

        // Write/read on one address.
        step("wr0a", 1'b1, 1'b1, 14'd0, 19'h00381);
        step("wr0b", 1'b1, 1'b1, 14'd0, 19'h00234);
        step("rd0", 1'b1, 1'b0, 14'd0, 19'h0);
        check("rd0Const", 32'(outIM), 32'h00234);

        // Multi-address, each returned one cycle after its address.
        step("wr1", 1'b1, 1'b1, 14'd1, 19'h00234);
        step("wr2", 1'b1, 1'b1, 14'd2, 19'h00381);
        step("rrd0", 1'b1, 1'b0, 14'd0, 19'h0);
        step("rrd1", 1'b1, 1'b0, 14'd1, 19'h0);
        check("rrd1Const", 32'(outIM), 32'h00234);
        step("rrd2", 1'b1, 1'b0, 14'd2, 19'h0);
        check("rrd2Const", 32'(outIM), 32'h00381);

        // Read-during-write then hold.
        step("rdw5", 1'b1, 1'b1, 14'd5, 19'h7FFFF);
        check("rdw5Const", 32'(outIM), 32'h7FFFF);
        step("rdw5Again", 1'b1, 1'b1, 14'd5, 19'h7FFFF);
        step("hold5a", 1'b1, 1'b0, 14'd5, 19'h0);
        step("hold5b", 1'b1, 1'b0, 14'd5, 19'h0);

        // Top and bottom of the address space must not alias.
        step("wrTop", 1'b1, 1'b1, hiAddr, 19'h12345);
        step("wrBot", 1'b1, 1'b1, 14'd0, 19'h00001);
        step("rdTop", 1'b1, 1'b0, hiAddr, 19'h0);
        check("rdTopConst", 32'(outIM), 32'h12345);
        step("rdBot", 1'b1, 1'b0, 14'd0, 19'h0);
        check("rdBotConst", 32'(outIM), 32'h00001);

        // Parity: corrupt one stored bit at addr 3.
        step("wr3", 1'b1, 1'b1, 14'd3, 19'h0A5C3);
`ifdef INSTMEM_PARITY_EN
        dut.mem[3] = dut.mem[3] ^ 19'h00010;
        model[3]   = model[3] ^ 19'h00010;
        corrupt[3] = 1'b1;
`endif
        step("rd3", 1'b1, 1'b0, 14'd3, 19'h0);
`ifdef INSTMEM_PARITY_EN
        check("parErr3", 32'(par_err), 32'd1);
`else
        check("parOff3", 32'(par_err), 32'd0);
`endif

        // Randomized traffic around both ends of the address space.
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 7))
                                             : 14'($urandom_range(16376, 16383));
            rd = 19'($urandom);
            rw = ($urandom_range(0, 2) == 0);
            rr = ($urandom_range(0, 19) != 0);
            step("rand", rr, rw, ra, rd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
